// File: rtl/mips_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state and instruction-class
// enums, IR field constants, datapath select encodings and the control-word layout.
package mips_defs;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_COP0   = 4'd10,
    S_INT    = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    IC_NOP  = 4'd0,
    IC_LW   = 4'd1,
    IC_SW   = 4'd2,
    IC_RALU = 4'd3,
    IC_IALU = 4'd4,
    IC_BEQ  = 4'd5,
    IC_J    = 4'd6,
    IC_JAL  = 4'd7,
    IC_JR   = 4'd8,
    IC_MFC0 = 4'd9,
    IC_MTC0 = 4'd10,
    IC_ERET = 4'd11,
    IC_CNOP = 4'd12
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_COP0  = 6'b010000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_ERET  = 6'b011000;

  localparam logic [4:0] RS_MFC0  = 5'b00000;
  localparam logic [4:0] RS_MTC0  = 5'b00100;
  localparam logic [4:0] RS_CO    = 5'b10000;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_LUI  = 3'd4;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_UP   = 2'd2;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;
  localparam logic [1:0] NPC_CP0  = 2'd3;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_PC    = 2'd2;
  localparam logic [1:0] WD_CP0   = 2'd3;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  localparam logic [1:0] CP0S_GPR = 2'd0;
  localparam logic [1:0] CP0S_EPC = 2'd1;
  localparam logic [1:0] CP0S_HND = 2'd2;

  // Exception vector selected by cp0_sel=CP0S_HND; the mux itself lives in the datapath.
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic [1:0] npc_sel;
    logic       ir_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic       mem_wr;
    logic       cp0_wr;
    logic       epc_wr;
    logic       exl_clr;
    logic [1:0] cp0_sel;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_fsm_decode.sv
// Combinational instruction classifier: IR opcode/rs/funct to instruction class plus
// the ALU setup used by the EXEC state.
module mips_ctrl_decode
  import mips_defs::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [5:0] funct,
  output iclass_e    iclass,
  output logic [2:0] alu_op,
  output logic [1:0] ext_op,
  output logic       alu_src
);

  always_comb begin
    iclass  = IC_NOP;
    alu_op  = ALU_ADD;
    ext_op  = EXT_ZERO;
    alu_src = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin iclass = IC_RALU; alu_op = ALU_ADD; end
          FN_SUBU: begin iclass = IC_RALU; alu_op = ALU_SUB; end
          FN_SLT:  begin iclass = IC_RALU; alu_op = ALU_SLT; end
          FN_JR:   iclass = IC_JR;
          default: iclass = IC_NOP;
        endcase
      end
      OP_ADDIU: begin
        iclass  = IC_IALU;
        alu_op  = ALU_ADD;
        ext_op  = EXT_SIGN;
        alu_src = 1'b1;
      end
      OP_ORI: begin
        iclass  = IC_IALU;
        alu_op  = ALU_OR;
        ext_op  = EXT_ZERO;
        alu_src = 1'b1;
      end
      OP_LUI: begin
        iclass  = IC_IALU;
        alu_op  = ALU_LUI;
        ext_op  = EXT_UP;
        alu_src = 1'b1;
      end
      OP_LW:  iclass = IC_LW;
      OP_SW:  iclass = IC_SW;
      OP_BEQ: iclass = IC_BEQ;
      OP_J:   iclass = IC_J;
      OP_JAL: iclass = IC_JAL;
      OP_COP0: begin
        // Unrecognised COP0 forms still spend a COP0 cycle, they just write nothing.
        if (rs == RS_MFC0)                          iclass = IC_MFC0;
        else if (rs == RS_MTC0)                     iclass = IC_MTC0;
        else if (rs == RS_CO && funct == FN_ERET)   iclass = IC_ERET;
        else                                        iclass = IC_CNOP;
      end
      default: iclass = IC_NOP;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/write-back,
// drives datapath enables and selects, and inserts an interrupt-entry cycle at boundaries.
module mips_ctrl_fsm
  import mips_defs::*;
#(
  parameter int INT_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       int_req,
  output logic       pc_wr,
  output logic       pc_wr_cond,
  output logic [1:0] npc_sel,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic [1:0] ext_op,
  output logic       mem_wr,
  output logic       cp0_wr,
  output logic       epc_wr,
  output logic       exl_clr,
  output logic [1:0] cp0_sel
);

  state_e     state_q, state_d;
  state_e     end_state;
  iclass_e    iclass;
  logic [2:0] dec_alu_op;
  logic [1:0] dec_ext_op;
  logic       dec_alu_src;
  ctrl_t      ctrl;

  // The branch decision is taken by the datapath through pc_wr_cond.
  logic unused_zero;
  assign unused_zero = zero;

  mips_ctrl_decode u_decode (
    .op      (op),
    .rs      (rs),
    .funct   (funct),
    .iclass  (iclass),
    .alu_op  (dec_alu_op),
    .ext_op  (dec_ext_op),
    .alu_src (dec_alu_src)
  );

  assign end_state = ((INT_EN != 0) && int_req) ? S_INT : S_FETCH;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (iclass)
          IC_LW, IC_SW:                        state_d = S_MEMADR;
          IC_RALU, IC_IALU:                    state_d = S_EXEC;
          IC_BEQ:                              state_d = S_BRANCH;
          IC_J, IC_JAL, IC_JR:                 state_d = S_JUMP;
          IC_MFC0, IC_MTC0, IC_ERET, IC_CNOP:  state_d = S_COP0;
          default:                             state_d = end_state;
        endcase
      end
      S_MEMADR: state_d = (iclass == IC_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP: state_d = end_state;
      // eret always returns to EPC so at least one instruction runs before re-entry.
      S_COP0:   state_d = (iclass == IC_ERET) ? S_FETCH : end_state;
      S_INT:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_wr   = 1'b1;
        ctrl.pc_wr   = 1'b1;
        ctrl.npc_sel = NPC_SEQ;
      end
      S_MEMADR: begin
        ctrl.alu_src = 1'b1;
        ctrl.ext_op  = EXT_SIGN;
        ctrl.alu_op  = ALU_ADD;
      end
      S_MEMWB: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.reg_dst = RD_RT;
        ctrl.wd_sel  = WD_MEM;
      end
      S_MEMWR: ctrl.mem_wr = 1'b1;
      S_EXEC: begin
        ctrl.alu_src = dec_alu_src;
        ctrl.alu_op  = dec_alu_op;
        ctrl.ext_op  = dec_ext_op;
      end
      S_ALUWB: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.reg_dst = (iclass == IC_RALU) ? RD_RD : RD_RT;
        ctrl.wd_sel  = WD_ALU;
      end
      S_BRANCH: begin
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_wr_cond = 1'b1;
        ctrl.npc_sel    = NPC_BR;
      end
      S_JUMP: begin
        case (iclass)
          IC_J: begin
            ctrl.pc_wr   = 1'b1;
            ctrl.npc_sel = NPC_JMP;
          end
          IC_JAL: begin
            ctrl.pc_wr   = 1'b1;
            ctrl.npc_sel = NPC_JMP;
            ctrl.reg_wr  = 1'b1;
            ctrl.reg_dst = RD_RA;
            ctrl.wd_sel  = WD_PC;
          end
          IC_JR: begin
            ctrl.pc_wr   = 1'b1;
            ctrl.npc_sel = NPC_CP0;
            ctrl.cp0_sel = CP0S_GPR;
          end
          default: ;
        endcase
      end
      S_COP0: begin
        case (iclass)
          IC_MFC0: begin
            ctrl.reg_wr  = 1'b1;
            ctrl.reg_dst = RD_RT;
            ctrl.wd_sel  = WD_CP0;
          end
          IC_MTC0: ctrl.cp0_wr = 1'b1;
          IC_ERET: begin
            ctrl.pc_wr   = 1'b1;
            ctrl.npc_sel = NPC_CP0;
            ctrl.cp0_sel = CP0S_EPC;
            ctrl.exl_clr = 1'b1;
          end
          default: ;
        endcase
      end
      S_INT: begin
        ctrl.epc_wr  = 1'b1;
        ctrl.pc_wr   = 1'b1;
        ctrl.npc_sel = NPC_CP0;
        ctrl.cp0_sel = CP0S_HND;
      end
      default: ;
    endcase
    // A reset cycle must not leave a partial write behind in any state.
    if (rst) ctrl = '0;
  end

  assign pc_wr      = ctrl.pc_wr;
  assign pc_wr_cond = ctrl.pc_wr_cond;
  assign npc_sel    = ctrl.npc_sel;
  assign ir_wr      = ctrl.ir_wr;
  assign reg_wr     = ctrl.reg_wr;
  assign reg_dst    = ctrl.reg_dst;
  assign wd_sel     = ctrl.wd_sel;
  assign alu_src    = ctrl.alu_src;
  assign alu_op     = ctrl.alu_op;
  assign ext_op     = ctrl.ext_op;
  assign mem_wr     = ctrl.mem_wr;
  assign cp0_wr     = ctrl.cp0_wr;
  assign epc_wr     = ctrl.epc_wr;
  assign exl_clr    = ctrl.exl_clr;
  assign cp0_sel    = ctrl.cp0_sel;

endmodule
